lfsr_seq_checker: RTL and testbench

//  Downstream consumer of the LFSR pseudo-random generator. Receives the generator's
//  N-bit output stream with a valid strobe and self-synchronises on the first valid sample.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_next_val.sv | 20 ++
 rtl/lfsr_seq_checker.sv | 202 ++++++++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and tap table for the LFSR generator/checker pair.
// Fibonacci taps are given as bit-index masks for widths 2..8.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } chk_state_t;

  localparam int N_MIN = 2;
  localparam int N_MAX = 8;

  function automatic logic [7:0] lfsr_taps(input int n);
    logic [7:0] t;
    case (n)
      2:       t = 8'h03;
      3:       t = 8'h06;
      4:       t = 8'h0C;
      5:       t = 8'h14;
      6:       t = 8'h30;
      7:       t = 8'h60;
      8:       t = 8'hB8;
      default: t = 8'h00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_next_val.sv
// Combinational next-state of an N-bit Fibonacci LFSR.
// Shared by the generator and the sequence checker.
module lfsr_next_val #(
  parameter int N = 4
) (
  input  logic [N-1:0] cur,
  output logic [N-1:0] nxt
);
  import lfsr_pkg::*;

  localparam logic [7:0] TAPS = lfsr_taps(N);

  logic fb;

  always_comb begin
    fb  = ^(cur & TAPS[N-1:0]);
    nxt = {cur[N-2:0], fb};
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising LFSR stream checker with lock and error counters.
// Define LFSR_CHK_PERIOD_EN to add sequence-period measurement outputs.
module lfsr_seq_checker #(
  parameter int N       = 4,
  parameter int LOSS_TH = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             zero_seen
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ok
`endif
);
  import lfsr_pkg::*;

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("lfsr_seq_checker: N must be 2..8");
  end
  if (LOSS_TH < 1 || LOSS_TH > 15) begin : g_bad_th
    $error("lfsr_seq_checker: LOSS_TH must be 1..15");
  end

  localparam logic [4:0]       LOSS_V = 5'(LOSS_TH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  chk_state_t       state_q, state_d;
  logic [N-1:0]     exp_q, exp_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             zero_q, zero_d;

  logic [N-1:0] nxt_data;
  logic         is_zero;
  logic         mismatch;
  logic [4:0]   miss_inc;
  logic         v_sync;
  logic         v_track;

  lfsr_next_val #(.N(N)) u_next (
    .cur (in_data),
    .nxt (nxt_data)
  );

  // a zero sample is never a legal LFSR value, so it always counts as a miss
  assign is_zero  = (in_data == '0);
  assign mismatch = is_zero || (in_data != exp_q);
  assign miss_inc = {1'b0, miss_q} + 5'd1;
  assign v_sync   = !start && in_valid && (state_q == SYNC) && !is_zero;
  assign v_track  = !start && in_valid && (state_q == TRACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      exp_q       <= '1;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      zero_q      <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SYNC;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        SYNC:  if (!is_zero) state_d = TRACK;
        TRACK: if (mismatch && miss_inc >= LOSS_V) state_d = SYNC;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    exp_d       = exp_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    zero_d      = zero_q;
    if (start) begin
      miss_d    = '0;
      err_cnt_d = '0;
      smp_cnt_d = '0;
      zero_d    = 1'b0;
    end else if (v_sync) begin
      exp_d  = nxt_data;
      miss_d = '0;
    end else if (v_track) begin
      exp_d     = nxt_data;
      smp_cnt_d = (&smp_cnt_q) ? smp_cnt_q : smp_cnt_q + ONE;
      if (mismatch) begin
        err_pulse_d = 1'b1;
        err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ONE;
        miss_d      = miss_inc[3:0];
        zero_d      = zero_q | is_zero;
      end else begin
        miss_d = '0;
      end
    end
  end

  always_comb begin
    locked     = (state_q == TRACK);
    err_pulse  = err_pulse_q;
    err_cnt    = err_cnt_q;
    sample_cnt = smp_cnt_q;
    zero_seen  = zero_q;
  end

`ifdef LFSR_CHK_PERIOD_EN
  localparam logic [CNT_W-1:0] FULL = CNT_W'((1 << N) - 1);

  logic [N-1:0]     ref_q, ref_d;
  logic             meas_q, meas_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             pv_q, pv_d;
  logic             pok_q, pok_d;
  logic [CNT_W-1:0] per_inc;

  assign per_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q     <= '0;
      meas_q    <= 1'b0;
      per_cnt_q <= '0;
      per_q     <= '0;
      pv_q      <= 1'b0;
      pok_q     <= 1'b0;
    end else begin
      ref_q     <= ref_d;
      meas_q    <= meas_d;
      per_cnt_q <= per_cnt_d;
      per_q     <= per_d;
      pv_q      <= pv_d;
      pok_q     <= pok_d;
    end
  end

  always_comb begin
    ref_d     = ref_q;
    meas_d    = meas_q;
    per_cnt_d = per_cnt_q;
    per_d     = per_q;
    pv_d      = pv_q;
    pok_d     = pok_q;
    if (start) begin
      meas_d    = 1'b0;
      per_cnt_d = '0;
      per_d     = '0;
      pv_d      = 1'b0;
      pok_d     = 1'b0;
    end else if (v_sync) begin
      ref_d     = in_data;
      meas_d    = 1'b1;
      per_cnt_d = '0;
    end else if (v_track && meas_q) begin
      if (in_data == ref_q) begin
        per_d  = per_inc;
        pv_d   = 1'b1;
        pok_d  = (per_inc == FULL);
        meas_d = 1'b0;
      end else begin
        per_cnt_d = per_inc;
      end
    end
  end

  always_comb begin
    period       = per_q;
    period_valid = pv_q;
    period_ok    = pok_q;
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker (N=4, LOSS_TH=3, CNT_W=16).
// With LFSR_CHK_PERIOD_EN an N=8 instance checks the 255-sample period.
module tb_lfsr_seq_checker;

  typedef struct packed {
    logic        l;
    logic        e;
    logic [15:0] ec;
    logic [15:0] sc;
    logic        z;
  } obs_t;

  typedef struct packed {
    int   due;
    int   id;
    obs_t o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        locked, err_pulse, zero_seen;
  logic [15:0] err_cnt, sample_cnt;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   sid = 0;
  exp_t q[$];

`ifdef LFSR_CHK_PERIOD_EN
  logic [15:0] period;
  logic        period_valid, period_ok;
  logic        s8 = 1'b0;
  logic        v8 = 1'b0;
  logic [7:0]  d8 = 8'h00;
  logic        l8, e8, z8, pv8, pok8;
  logic [15:0] ec8, sc8, per8;
`endif

  always #5 clk = ~clk;

  lfsr_seq_checker #(.N(4), .LOSS_TH(3), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .sample_cnt (sample_cnt),
    .zero_seen  (zero_seen)
`ifdef LFSR_CHK_PERIOD_EN
    ,
    .period       (period),
    .period_valid (period_valid),
    .period_ok    (period_ok)
`endif
  );

`ifdef LFSR_CHK_PERIOD_EN
  lfsr_seq_checker #(.N(8), .LOSS_TH(3), .CNT_W(16)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (s8),
    .in_valid     (v8),
    .in_data      (d8),
    .locked       (l8),
    .err_pulse    (e8),
    .err_cnt      (ec8),
    .sample_cnt   (sc8),
    .zero_seen    (z8),
    .period       (per8),
    .period_valid (pv8),
    .period_ok    (pok8)
  );
`endif

  function automatic obs_t mk(input logic l, input logic e,
                              input int ec, input int sc,
                              input logic z);
    return '{l: l, e: e, ec: 16'(ec), sc: 16'(sc), z: z};
  endfunction

  function automatic obs_t act();
    return '{l: locked, e: err_pulse, ec: err_cnt,
             sc: sample_cnt, z: zero_seen};
  endfunction

  function automatic logic [3:0] nx4(input logic [3:0] c);
    return {c[2:0], c[3] ^ c[2]};
  endfunction

  function automatic logic [7:0] nx8(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  task automatic report(input string nm, input int id,
                        input obs_t a, input obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s%0d got l=%0b ep=%0b ec=%0d sc=%0d z=%0b want l=%0b ep=%0b ec=%0d sc=%0d z=%0b",
               nm, id, a.l, a.e, a.ec, a.sc, a.z,
               e.l, e.e, e.ec, e.sc, e.z);
    end
  endtask

  task automatic cmp(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  // drive one cycle and queue the response due after the next edge
  task automatic step(input logic st, input logic v, input logic [3:0] d,
                      input logic l, input logic e, input int ec,
                      input int sc, input logic z);
    @(negedge clk);
    start    = st;
    in_valid = v;
    in_data  = d;
    sid++;
    q.push_back('{due: cyc + 1, id: sid, o: mk(l, e, ec, sc, z)});
  endtask

  task automatic drv(input logic st, input logic v, input logic [3:0] d);
    @(negedge clk);
    start    = st;
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    logic [3:0] c4;
`ifdef LFSR_CHK_PERIOD_EN
    logic [7:0] c8;
`endif
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].due == cyc) begin
          exp_t x;
          x = q.pop_front();
          report("step", x.id, act(), x.o);
        end
      end
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
      end
    join_none

    repeat (2) @(negedge clk);
    report("reset", 0, act(), mk(0, 0, 0, 0, 0));
    reset_n = 1'b1;

    // clean lock and tracking
    step(1, 0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'hF, 1, 0, 0, 0, 0);
    step(0, 1, 4'hE, 1, 0, 0, 1, 0);
    step(0, 1, 4'hC, 1, 0, 0, 2, 0);
    step(0, 1, 4'h8, 1, 0, 0, 3, 0);
    step(0, 1, 4'h1, 1, 0, 0, 4, 0);
    step(0, 1, 4'h2, 1, 0, 0, 5, 0);
    step(0, 1, 4'h4, 1, 0, 0, 6, 0);
    step(0, 1, 4'h9, 1, 0, 0, 7, 0);
    step(0, 0, 4'h5, 1, 0, 0, 7, 0);

    // single injected error, resync on data
    step(1, 0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'hF, 1, 0, 0, 0, 0);
    step(0, 1, 4'hE, 1, 0, 0, 1, 0);
    step(0, 1, 4'hC, 1, 0, 0, 2, 0);
    step(0, 1, 4'h5, 1, 1, 1, 3, 0);
    step(0, 1, 4'hB, 1, 0, 1, 4, 0);
    step(0, 1, 4'h7, 1, 0, 1, 5, 0);
    step(0, 1, 4'hF, 1, 0, 1, 6, 0);

    // loss of lock after three misses, then relock
    step(1, 0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'hF, 1, 0, 0, 0, 0);
    step(0, 1, 4'hE, 1, 0, 0, 1, 0);
    step(0, 1, 4'hC, 1, 0, 0, 2, 0);
    step(0, 1, 4'hA, 1, 1, 1, 3, 0);
    step(0, 1, 4'hA, 1, 1, 2, 4, 0);
    step(0, 1, 4'hA, 0, 1, 3, 5, 0);
    step(0, 1, 4'h3, 1, 0, 3, 5, 0);
    step(0, 1, 4'h6, 1, 0, 3, 6, 0);

    // zeros ignored in SYNC, flagged in TRACK; start beats a sample
    step(1, 0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'hF, 1, 0, 0, 0, 0);
    step(0, 1, 4'hE, 1, 0, 0, 1, 0);
    step(0, 1, 4'h0, 1, 1, 1, 2, 1);
    step(1, 1, 4'hC, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 1, 4'hF, 1, 0, 0, 0, 0);
    step(0, 1, 4'hE, 1, 0, 0, 1, 0);
    step(0, 0, 4'h0, 1, 0, 0, 1, 0);
    repeat (2) @(negedge clk);

    // asynchronous reset between edges
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 report("async_rst", 0, act(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 4'hF, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

`ifdef LFSR_CHK_PERIOD_EN
    drv(1, 0, 4'h0);
    c4 = 4'hF;
    drv(0, 1, c4);
    repeat (15) begin
      c4 = nx4(c4);
      drv(0, 1, c4);
    end
    drv(0, 0, 4'h0);
    cmp("period4", int'(period), 15);
    cmp("pvalid4", int'(period_valid), 1);
    cmp("pok4", int'(period_ok), 1);

    drv(1, 0, 4'h0);
    drv(0, 1, 4'hF);
    drv(0, 1, 4'hE);
    c4 = 4'h8;
    drv(0, 1, c4);
    while (c4 != 4'hF) begin
      c4 = nx4(c4);
      drv(0, 1, c4);
    end
    drv(0, 0, 4'h0);
    cmp("period4_skip", int'(period), 14);
    cmp("pok4_skip", int'(period_ok), 0);

    @(negedge clk);
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    v8 = 1'b1;
    c8 = 8'hFF;
    d8 = c8;
    repeat (255) begin
      @(negedge clk);
      c8 = nx8(c8);
      d8 = c8;
    end
    @(negedge clk);
    v8 = 1'b0;
    cmp("period8", int'(per8), 255);
    cmp("pok8", int'(pok8), 1);
    cmp("errcnt8", int'(ec8), 0);
`else
    c4 = 4'h0;
`endif

    cmp("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
